// File: rtl/imm_pkg.sv
// Shared immediate-type selector codes for the decode-stage immediate extender.
// Imported by imm_extend_core and imm_extend_pipe.
package imm_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t IMM_I = 3'b000;
    localparam imm_sel_t IMM_S = 3'b001;
    localparam imm_sel_t IMM_B = 3'b010;
    localparam imm_sel_t IMM_J = 3'b011;
    localparam imm_sel_t IMM_U = 3'b100;
    localparam imm_sel_t IMM_Z = 3'b101;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational RISC-V immediate extender, XLEN-parametrised.
// Build option: IMM_ZIMM_EN makes selector 101 a legal CSR zimm type.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_sel_t        immsrc,
    output logic [XLEN-1:0] immext,
    output logic            err
);

    logic               s;
    logic signed [31:0] imm32;
    logic               legal;
    logic               zimm;
    logic               unused_opcode;

    // Opcode field carries no immediate bits
    assign unused_opcode = ^instr[6:0];
    assign s = instr[31];

    // Build the 32-bit sign-extended immediate per type
    always_comb begin
        imm32 = '0;
        legal = 1'b1;
        zimm  = 1'b0;
        case (immsrc)
            IMM_I: imm32 = {{20{s}}, instr[31:20]};
            IMM_S: imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{20{s}}, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J: imm32 = {{12{s}}, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_Z: begin
`ifdef IMM_ZIMM_EN
                zimm  = 1'b1;
`else
                legal = 1'b0;
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    // Widen to XLEN; zimm is zero-extended, everything else sign-extended
    always_comb begin
        immext = '0;
        err    = ~legal;
        if (zimm) begin
            immext = XLEN'(instr[19:15]);
        end else if (legal) begin
            immext = XLEN'(imm32);
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with an in-order DEPTH-entry output FIFO.
// Build option: IMM_ZIMM_EN enables the CSR zimm selector (101).
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_err [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [XLEN-1:0]  ext_imm;
    logic             ext_err;
    logic             push;
    logic             pop;

    imm_extend_core #(
        .XLEN(XLEN)
    ) u_core (
        .instr  (in_instr),
        .immsrc (imm_sel_t'(in_immsrc)),
        .immext (ext_imm),
        .err    (ext_err)
    );

    // Handshake status comes from registered count only
    always_comb begin
        in_ready  = (count != FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Head entry drives outputs; zeros while empty
    always_comb begin
        out_immext = '0;
        out_tag    = '0;
        out_err    = 1'b0;
        if (out_valid) begin
            out_immext = mem_imm[rd_ptr];
            out_tag    = mem_tag[rd_ptr];
            out_err    = mem_err[rd_ptr];
        end
    end

    // FIFO storage written at the tail on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_tag[i] <= '0;
                mem_err[i] <= 1'b0;
            end
        end else if (push) begin
            mem_imm[wr_ptr] <= ext_imm;
            mem_tag[wr_ptr] <= in_tag;
            mem_err[wr_ptr] <= ext_err;
        end
    end

    // Pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (XLEN=32 and XLEN=64).
// Expectations for selector 101 follow the IMM_ZIMM_EN build option.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_immext;
    logic [4:0]  out_tag;
    logic        out_err;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_instr;
    logic [2:0]  w_in_immsrc;
    logic [4:0]  w_in_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_immext;
    logic [4:0]  w_out_tag;
    logic        w_out_err;

    int checks;
    int errors;

    imm_extend_pipe #(
        .XLEN(32), .TAG_W(5), .DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_immsrc  (in_immsrc),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_immext (out_immext),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    imm_extend_pipe #(
        .XLEN(64), .TAG_W(5), .DEPTH(2)
    ) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_instr   (w_in_instr),
        .in_immsrc  (w_in_immsrc),
        .in_tag     (w_in_tag),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_immext (w_out_immext),
        .out_tag    (w_out_tag),
        .out_err    (w_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_immext !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%b want 0/0/0",
                     out_immext, out_tag, out_err);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 1/1", in_ready, w_in_ready);
        end
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_immsrc = 3'b000;
        in_tag    = 5'd5;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_immext !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL itype got v=%b %h want v=1 ffffffff",
                     out_valid, out_immext);
        end
        checks++;
        if (out_tag !== 5'd5 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL itype_tag got %0d/%b want 5/0", out_tag, out_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL itype_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_stype();
        in_valid  = 1'b1;
        in_instr  = 32'hFE112E23;
        in_immsrc = 3'b001;
        in_tag    = 5'd6;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_immext !== 32'hFFFFFFFC || out_err !== 1'b0) begin
            errors++;
            $display("FAIL stype got %h/%b want fffffffc/0", out_immext, out_err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        in_valid  = 1'b1;
        in_instr  = 32'hFE000EE3;
        in_immsrc = 3'b010;
        in_tag    = 5'd10;
        step();
        in_instr  = 32'h0080006F;
        in_immsrc = 3'b011;
        in_tag    = 5'd11;
        checks++;
        if (out_valid !== 1'b1 || out_immext !== 32'hFFFFFFFC
            || out_tag !== 5'd10) begin
            errors++;
            $display("FAIL b2b_btype got v=%b %h t=%0d want v=1 fffffffc t=10",
                     out_valid, out_immext, out_tag);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_immext !== 32'h00000008
            || out_tag !== 5'd11) begin
            errors++;
            $display("FAIL b2b_jtype got v=%b %h t=%0d want v=1 00000008 t=11",
                     out_valid, out_immext, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_xlen64();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_instr  = 32'h800002B7;
        w_in_immsrc = 3'b100;
        w_in_tag    = 5'd3;
        step();
        w_in_instr  = 32'hFFF00093;
        w_in_immsrc = 3'b000;
        w_in_tag    = 5'd4;
        checks++;
        if (w_out_immext !== 64'hFFFFFFFF80000000 || w_out_tag !== 5'd3) begin
            errors++;
            $display("FAIL x64_utype got %h t=%0d want ffffffff80000000 t=3",
                     w_out_immext, w_out_tag);
        end
        step();
        w_in_valid = 1'b0;
        checks++;
        if (w_out_immext !== 64'hFFFFFFFFFFFFFFFF || w_out_err !== 1'b0) begin
            errors++;
            $display("FAIL x64_itype got %h/%b want ffffffffffffffff/0",
                     w_out_immext, w_out_err);
        end
        step();
    endtask

    task automatic test_fifo_order();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_immsrc = 3'b000;
        in_tag    = 5'd1;
        step();
        in_tag = 5'd2;
        step();
        in_tag = 5'd3;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready got %b want 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 5'd1) begin
            errors++;
            $display("FAIL fifo_hold got rdy=%b t=%0d want rdy=0 t=1",
                     in_ready, out_tag);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_tag !== 5'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_pop1 got t=%0d rdy=%b want t=2 rdy=1",
                     out_tag, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd3) begin
            errors++;
            $display("FAIL fifo_pop2 got v=%b t=%0d want v=1 t=3",
                     out_valid, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] zexp;
        logic        zerr;
`ifdef IMM_ZIMM_EN
        zexp = 32'h00000015;
        zerr = 1'b0;
`else
        zexp = 32'h0;
        zerr = 1'b1;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFFFFFFF;
        in_immsrc = 3'b111;
        in_tag    = 5'd7;
        step();
        in_instr  = 32'h800A8073;
        in_immsrc = 3'b101;
        in_tag    = 5'd8;
        checks++;
        if (out_err !== 1'b1 || out_immext !== 32'h0 || out_tag !== 5'd7) begin
            errors++;
            $display("FAIL illegal111 got err=%b %h t=%0d want err=1 0 t=7",
                     out_err, out_immext, out_tag);
        end
        step();
        in_instr  = 32'hFFFFFFFF;
        in_immsrc = 3'b110;
        in_tag    = 5'd9;
        checks++;
        if (out_err !== zerr || out_immext !== zexp) begin
            errors++;
            $display("FAIL zimm101 got err=%b %h want err=%b %h",
                     out_err, out_immext, zerr, zexp);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_err !== 1'b1 || out_immext !== 32'h0) begin
            errors++;
            $display("FAIL illegal110 got err=%b %h want err=1 0",
                     out_err, out_immext);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h7FF00093;
        in_immsrc = 3'b000;
        in_tag    = 5'd20;
        step();
        in_tag = 5'd21;
        step();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL midrst_async got v=%b rdy=%b t=%0d want v=0 rdy=1 t=0",
                     out_valid, in_ready, out_tag);
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release got v=%b rdy=%b want v=0 rdy=1",
                     out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_tag   = 5'd22;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd22
            || out_immext !== 32'h000007FF) begin
            errors++;
            $display("FAIL midrst_fresh got v=%b t=%0d %h want v=1 t=22 000007ff",
                     out_valid, out_tag, out_immext);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nostale got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_immsrc   = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_instr  = '0;
        w_in_immsrc = '0;
        w_in_tag    = '0;
        w_out_ready = 1'b0;
        test_reset();
        test_itype();
        test_stype();
        test_back_to_back();
        test_xlen64();
        test_fifo_order();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
